iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Per-thread arithmetic unit for the SIMT core. Replaces the fixed 8-bit single-cycle ALU.
- Parametrised data width.
- Runtime signed/unsigned mode.
- Adds REM and explicit CMP ops.
- Iterative multi-cycle divider with a start/busy/done handshake, so the core scheduler can stall on long ops.
- One instance per thread lane; driven by the decoder/scheduler in the EXECUTE stage.

Parameters:
- DATA_WIDTH, 8, operand/result width W (>=4).
- DIV_CNT_W, $clog2(DATA_WIDTH+1), width of the divider iteration counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  lane active; low freezes all state
- start  in  1  op request, sampled when enable && !busy
- op  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5 CMP; 6-7 reserved
- signed_mode  in  1  1 = two's-complement operands
- rs  in  W  operand A
- rt  in  W  operand B
- result  out  W  registered result
- nzp  out  3  {positive, zero, negative} flags of the completed op
- busy  out  1  DIV/REM iteration in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  sticky until next accepted start

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE.
- Reset mid-operation: abort, IDLE next cycle, no done pulse.
- Accept: at an edge with enable && start && !busy, the op is latched.
- start while busy: ignored, not queued.
- Reserved op: completes in 1 cycle with result=0, nzp=010.
- States:
  - IDLE -> RUN: on accepted DIV/REM with rt!=0.
  - RUN: one restoring quotient bit per cycle for W cycles; counter counts W-1 down to 0.
  - RUN -> FIX: after the last bit.
  - FIX: apply sign correction, write result, pulse done -> IDLE.
- Latency, start edge to done-high cycle:
  - ADD/SUB/MUL/CMP: 1 (result, nzp, done registered on the accept edge).
  - DIV/REM: W+2.
  - Divide by zero: 1.
- busy: high from the edge after accept through the FIX edge; low in the cycle done is high.
- enable low in RUN/FIX: state, counter and partial remainder hold; latency extends 1 cycle per stalled cycle; done is not pulsed while enable is low.
- Arithmetic:
  - ADD/SUB/MUL: results truncated to W bits (low half of the product). Identical bits for signed and unsigned.
- DIV/REM:
  - Signed mode: divide magnitudes; quotient truncates toward zero; remainder takes the sign of rs.
  - Signed MIN / -1: quotient = MIN, remainder = 0, no flag.
- Divide by zero: quotient = all ones; remainder = rs; div_by_zero=1.
- CMP:
  - result = {0…, gt, eq, lt}, compared per signed_mode.
  - No overflow from subtraction is involved.
- nzp:
  - CMP: nzp = {gt, eq, lt}.
  - Other ops: sign/zero of result (negative only if signed_mode and result MSB set).
  - Updated only on a done edge; otherwise held.
- result holds its last value between completions.
- done is never high in two consecutive cycles for DIV/REM.
- Back-to-back 1-cycle ops are allowed every cycle.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (3-bit codes above).
  - alu_state_e {IDLE, RUN, FIX}.
  - NZP bit-index constants.
- Sub-module div_iter: unsigned restoring divider core.
  - Interface: load, W-bit dividend/divisor magnitudes, step enable, quotient/remainder outputs, last-step flag.
  - iter_alu owns sign handling, the FSM and the handshake.

Test Plan (W=8):
- ADD unsigned, rs=100, rt=100 -> result=0xC8, nzp=100, done 1 cycle after start, busy never high.
- CMP rs=0xFD, rt=0x02:
  - signed -> result=0x01, nzp=001.
  - unsigned -> result=0x04, nzp=100.
- Signed DIV rs=-7 (0xF9), rt=2 -> result=0xFD, nzp=001, done exactly 10 cycles after start.
- Signed REM with the same operands -> result=0xFF.
- DIV rs=5, rt=0 -> result=0xFF, div_by_zero=1, done after 1 cycle. The next accepted ADD clears div_by_zero.
- Signed DIV 0x80/0xFF -> result=0x80, nzp=001.
- start pulsed during busy -> ignored, single done.
- enable low for 3 cycles mid-RUN -> done at 13 cycles.
- Reset asserted at cycle 4 of a DIV -> next cycle busy=0, result=0, nzp=000, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the per-lane iterative ALU: op codes, FSM states and nzp bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_REM = 3'd4,
    ALU_CMP = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } alu_state_e;

  // nzp is packed as {positive, zero, negative}
  localparam int NZP_P = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_N = 0;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core: one quotient bit per step, MSB first.
module div_iter #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_CNT_W  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  last
);

  logic [DATA_WIDTH-1:0] dvsr_q;
  logic [DIV_CNT_W-1:0]  cnt_q;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fits;

  // quotient doubles as the dividend shift register; its MSB feeds the remainder
  always_comb begin
    shifted = {remainder, quotient[DATA_WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr_q});
    diff    = shifted[DATA_WIDTH-1:0] - dvsr_q;
  end

  assign last = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr_q    <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      dvsr_q    <= divisor;
      cnt_q     <= DIV_CNT_W'(DATA_WIDTH - 1);
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      remainder <= fits ? diff : shifted[DATA_WIDTH-1:0];
      quotient  <= {quotient[DATA_WIDTH-2:0], fits};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Per-lane SIMT ALU: single-cycle ADD/SUB/MUL/CMP, iterative signed/unsigned DIV/REM
// with a start/busy/done handshake so the scheduler can stall on long ops.
module iter_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_CNT_W  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] result,
  output logic [2:0]            nzp,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int W = DATA_WIDTH;

  function automatic logic [2:0] flags_of(input logic [W-1:0] value, input logic sgn);
    logic [2:0] f;
    f        = '0;
    f[NZP_Z] = (value == '0);
    f[NZP_N] = sgn && value[W-1];
    f[NZP_P] = !f[NZP_Z] && !f[NZP_N];
    return f;
  endfunction

  alu_state_e   state_q, state_d;
  logic         accept, is_div, div_zero, a_neg, b_neg, lt, eq, gt;
  logic         div_load, div_step, div_last;
  logic         is_rem_q, sgn_q, neg_quo_q, neg_rem_q;
  logic [W-1:0] mag_a, mag_b, quo, rem, one_res, fix_mag, fix_res;
  logic [2:0]   one_nzp;

  assign busy = (state_q != IDLE);

  always_comb begin
    accept   = enable && start && !busy;
    is_div   = (op == ALU_DIV) || (op == ALU_REM);
    div_zero = (rt == '0);
    a_neg    = signed_mode && rs[W-1];
    b_neg    = signed_mode && rt[W-1];
    mag_a    = a_neg ? -rs : rs;
    mag_b    = b_neg ? -rt : rt;
    eq       = (rs == rt);
    lt       = signed_mode ? ($signed(rs) < $signed(rt)) : (rs < rt);
    gt       = !lt && !eq;
    one_res  = '0;
    case (op)
      ALU_ADD: one_res = rs + rt;
      ALU_SUB: one_res = rs - rt;
      ALU_MUL: one_res = rs * rt;
      ALU_DIV: one_res = '1;
      ALU_REM: one_res = rs;
      ALU_CMP: one_res = {{(W-3){1'b0}}, gt, eq, lt};
      default: one_res = '0;
    endcase
    one_nzp = (op == ALU_CMP) ? {gt, eq, lt} : flags_of(one_res, signed_mode);
  end

  // magnitudes are divided; signs are restored in FIX (MIN / -1 wraps back to MIN)
  always_comb begin
    fix_mag = is_rem_q ? rem : quo;
    fix_res = (is_rem_q ? neg_rem_q : neg_quo_q) ? -fix_mag : fix_mag;
  end

  always_comb begin
    state_d  = state_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_div && !div_zero) begin
          state_d  = RUN;
          div_load = 1'b1;
        end
      end
      RUN: begin
        if (enable) begin
          div_step = 1'b1;
          if (div_last) state_d = FIX;
        end
      end
      FIX: begin
        if (enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      nzp         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      is_rem_q    <= 1'b0;
      sgn_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_by_zero <= is_div && div_zero;
        is_rem_q    <= (op == ALU_REM);
        sgn_q       <= signed_mode;
        neg_quo_q   <= a_neg ^ b_neg;
        neg_rem_q   <= a_neg;
        if (!div_load) begin
          result <= one_res;
          nzp    <= one_nzp;
          done   <= 1'b1;
        end
      end
      if (enable && state_q == FIX) begin
        result <= fix_res;
        nzp    <= flags_of(fix_res, sgn_q);
        done   <= 1'b1;
      end
    end
  end

  div_iter #(
    .DATA_WIDTH(W),
    .DIV_CNT_W (DIV_CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quo),
    .remainder(rem),
    .last     (div_last)
  );

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (W=8): expected results are queued at issue time
// and popped when the DUT signals done.
module tb_iter_alu;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                         OP_DIV = 3'd3, OP_REM = 3'd4, OP_CMP = 3'd5, OP_RSV = 3'd6;

  logic         clk = 1'b0;
  logic         reset, enable, start, signed_mode;
  logic [2:0]   op;
  logic [W-1:0] rs, rt, result;
  logic [2:0]   nzp;
  logic         busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   nzp;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   o;
    logic         sm;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } stim_t;

  exp_t exp_q[$];

  iter_alu #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .op         (op),
    .signed_mode(signed_mode),
    .rs         (rs),
    .rt         (rt),
    .result     (result),
    .nzp        (nzp),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] sign_flags(input logic [W-1:0] v, input logic sm);
    logic n, z;
    n = sm && v[W-1];
    z = (v == '0);
    return {!n && !z, z, n};
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic sm,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa, sb;
    logic lt, eq, gt;
    sa = a;
    sb = b;
    e.dbz = 1'b0;
    e.lat = 1;
    e.res = '0;
    eq = (a == b);
    lt = sm ? (sa < sb) : (a < b);
    gt = !lt && !eq;
    case (o)
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_MUL: e.res = a * b;
      OP_DIV, OP_REM: begin
        if (b == '0) begin
          e.dbz = 1'b1;
          e.res = (o == OP_DIV) ? {W{1'b1}} : a;
        end else begin
          e.lat = W + 2;
          if (sm && a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}})
            e.res = (o == OP_DIV) ? a : '0;
          else if (sm)
            e.res = (o == OP_DIV) ? W'(sa / sb) : W'(sa % sb);
          else
            e.res = (o == OP_DIV) ? a / b : a % b;
        end
      end
      OP_CMP: e.res = W'({gt, eq, lt});
      default: e.res = '0;
    endcase
    e.nzp = (o == OP_CMP) ? {gt, eq, lt} : sign_flags(e.res, sm);
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic sm,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; signed_mode = sm; rs = a; rt = b; start = 1'b1;
    exp_q.push_back(model(o, sm, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; start = 1'b0; op = OP_ADD;
    signed_mode = 1'b0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
    total++; if (nzp !== 3'b000) begin bad++; $display("FAIL reset_nzp got=%b want=000", nzp); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
  endtask

  task automatic test_ops;
    stim_t tbl[$];
    exp_t  e;
    int    lat;
    logic  busy0;
    tbl.push_back('{OP_ADD, 1'b0, 8'd100, 8'd100});
    tbl.push_back('{OP_CMP, 1'b1, 8'hFD, 8'h02});
    tbl.push_back('{OP_CMP, 1'b0, 8'hFD, 8'h02});
    tbl.push_back('{OP_DIV, 1'b1, 8'hF9, 8'h02});
    tbl.push_back('{OP_REM, 1'b1, 8'hF9, 8'h02});
    tbl.push_back('{OP_DIV, 1'b0, 8'h05, 8'h00});
    tbl.push_back('{OP_DIV, 1'b1, 8'h80, 8'hFF});
    tbl.push_back('{OP_REM, 1'b1, 8'h80, 8'hFF});
    tbl.push_back('{OP_RSV, 1'b0, 8'h12, 8'h34});
    tbl.push_back('{OP_SUB, 1'b1, 8'h03, 8'h05});
    tbl.push_back('{OP_MUL, 1'b0, 8'h13, 8'h11});
    tbl.push_back('{OP_DIV, 1'b0, 8'd200, 8'd7});
    tbl.push_back('{OP_REM, 1'b0, 8'd200, 8'd7});
    tbl.push_back('{OP_DIV, 1'b1, 8'h64, 8'hF3});
    tbl.push_back('{OP_REM, 1'b1, 8'h9C, 8'h0D});
    tbl.push_back('{OP_REM, 1'b1, 8'hF9, 8'h00});
    tbl.push_back('{OP_CMP, 1'b1, 8'h7F, 8'h7F});
    foreach (tbl[i]) begin
      issue(tbl[i].o, tbl[i].sm, tbl[i].a, tbl[i].b);
      busy0 = busy;
      wait_done(lat);
      e = exp_q.pop_front();
      total++; if (busy0 !== (e.lat != 1)) begin bad++; $display("FAIL ops%0d_busy got=%b want=%b", i, busy0, (e.lat != 1)); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL ops%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      total++; if (result !== e.res) begin bad++; $display("FAIL ops%0d_result got=%h want=%h", i, result, e.res); end
      total++; if (nzp !== e.nzp) begin bad++; $display("FAIL ops%0d_nzp got=%b want=%b", i, nzp, e.nzp); end
      total++; if (div_by_zero !== e.dbz) begin bad++; $display("FAIL ops%0d_dbz got=%b want=%b", i, div_by_zero, e.dbz); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ops%0d_busy_at_done got=%b want=0", i, busy); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL ops%0d_done_pulse got=%b want=0", i, done); end
    end
  endtask

  task automatic test_dbz_sticky;
    exp_t e;
    int   lat;
    issue(OP_DIV, 1'b0, 8'h05, 8'h00);
    wait_done(lat);
    e = exp_q.pop_front();
    total++; if (result !== e.res) begin bad++; $display("FAIL dbz_result got=%h want=%h", result, e.res); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_sticky got=%b want=1", div_by_zero); end
    issue(OP_ADD, 1'b0, 8'h01, 8'h02);
    e = exp_q.pop_front();
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b want=0", div_by_zero); end
    total++; if (result !== e.res) begin bad++; $display("FAIL dbz_add_result got=%h want=%h", result, e.res); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops[4];
    exp_t       e;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_MUL; ops[3] = OP_CMP;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 3)];
      signed_mode = 1'($urandom_range(0, 1));
      rs = W'($urandom);
      rt = W'($urandom);
      start = 1'b1;
      exp_q.push_back(model(op, signed_mode, rs, rt));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b%0d_done got=%b want=1", i, done); end
      total++; if (result !== e.res) begin bad++; $display("FAIL b2b%0d_result got=%h want=%h", i, result, e.res); end
      total++; if (nzp !== e.nzp) begin bad++; $display("FAIL b2b%0d_nzp got=%b want=%b", i, nzp, e.nzp); end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_start_busy;
    exp_t         e;
    int           lat, dones, done_lat;
    logic [W-1:0] done_res;
    issue(OP_DIV, 1'b0, 8'd200, 8'd7);
    e = exp_q.pop_front();
    lat = 1; dones = 0; done_lat = -1; done_res = '0;
    for (int k = 0; k < 14; k++) begin
      start = (k < 5);
      op = OP_ADD; rs = 8'h01; rt = 8'h01;
      @(posedge clk); #1;
      lat++;
      if (done) begin
        dones++;
        done_lat = lat;
        done_res = result;
      end
    end
    start = 1'b0;
    total++; if (dones != 1) begin bad++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
    total++; if (done_lat != e.lat) begin bad++; $display("FAIL busy_start_latency got=%0d want=%0d", done_lat, e.lat); end
    total++; if (done_res !== e.res) begin bad++; $display("FAIL busy_start_result got=%h want=%h", done_res, e.res); end
  endtask

  task automatic test_stall;
    exp_t e;
    int   lat;
    issue(OP_DIV, 1'b1, 8'hF9, 8'h02);
    e = exp_q.pop_front();
    lat = 1;
    while (!done && lat < 40) begin
      enable = !(lat >= 3 && lat <= 5);
      @(posedge clk); #1;
      lat++;
    end
    enable = 1'b1;
    if (!done) lat = -1;
    total++; if (lat != e.lat + 3) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", lat, e.lat + 3); end
    total++; if (result !== e.res) begin bad++; $display("FAIL stall_result got=%h want=%h", result, e.res); end
    total++; if (nzp !== e.nzp) begin bad++; $display("FAIL stall_nzp got=%b want=%b", nzp, e.nzp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int dones;
    issue(OP_DIV, 1'b0, 8'd200, 8'd7);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (result !== '0) begin bad++; $display("FAIL rstmid_result got=%h want=00", result); end
    total++; if (nzp !== 3'b000) begin bad++; $display("FAIL rstmid_nzp got=%b want=000", nzp); end
    dones = done ? 1 : 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rstmid_done_count got=%0d want=0", dones); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_dbz_sticky();
    test_back_to_back();
    test_start_busy();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
